// File: rtl/pixel_proc_pkg.sv
// Shared types and helpers for the streaming pixel processor.
package pixel_proc_pkg;

  typedef enum logic [2:0] {
    MODE_PASS   = 3'd0,
    MODE_BRIGHT = 3'd1,
    MODE_INVERT = 3'd2,
    MODE_THRESH = 3'd3,
    MODE_GRAY   = 3'd4
  } mode_e;

  localparam int unsigned CH_R   = 0;
  localparam int unsigned CH_G   = 1;
  localparam int unsigned CH_B   = 2;
  localparam int unsigned NUM_CH = 3;

  // Widest channel the saturating helper supports; callers zero-extend into it.
  localparam int unsigned SAT_W = 16;

  // Add (dec=0) clamped to maxv, or subtract (dec=1) clamped to zero.
  function automatic logic [SAT_W-1:0] sat_addsub(input logic [SAT_W-1:0] c,
                                                  input logic [SAT_W-1:0] v,
                                                  input logic [SAT_W-1:0] maxv,
                                                  input logic             dec);
    logic [SAT_W:0] sum;
    sum = {1'b0, c} + {1'b0, v};
    if (dec) begin
      return (c < v) ? '0 : c - v;
    end
    return (sum > {1'b0, maxv}) ? maxv : sum[SAT_W-1:0];
  endfunction

endpackage

// File: rtl/pixel_stream_proc_if.sv
// Input and output pixel streams of the processor; master is the environment side.
interface pixel_stream_proc_if #(
  parameter int unsigned DATA_W = 8
) ();

  logic                  in_valid;
  logic                  in_ready;
  logic [3*DATA_W-1:0]   in_data;
  logic                  out_valid;
  logic                  out_ready;
  logic [3*DATA_W-1:0]   out_data;
  logic                  out_sof;
  logic                  out_eol;
  logic                  out_eof;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_sof, out_eol, out_eof
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_sof, out_eol, out_eof
  );

endinterface

// File: rtl/pixel_op_channel.sv
// Stage-2 point operation for a single colour channel.
module pixel_op_channel
  import pixel_proc_pkg::*;
#(
  parameter int unsigned DATA_W = 8
) (
  input  mode_e             mode_i,
  input  logic [DATA_W-1:0] c_i,
  input  logic [DATA_W-1:0] gray_i,
  input  logic              bright_dir_i,
  input  logic [DATA_W-1:0] bright_val_i,
  input  logic [DATA_W-1:0] thresh_i,
  output logic [DATA_W-1:0] res_o
);

  localparam logic [DATA_W-1:0] MAXV = '1;

  // Select the result for the frame's latched mode; unused encodings pass through.
  always_comb begin
    res_o = c_i;
    case (mode_i)
      MODE_BRIGHT: res_o = DATA_W'(sat_addsub(SAT_W'(c_i), SAT_W'(bright_val_i),
                                              SAT_W'(MAXV), bright_dir_i));
      MODE_INVERT: res_o = MAXV - c_i;
      MODE_THRESH: res_o = (gray_i >= thresh_i) ? MAXV : '0;
      MODE_GRAY:   res_o = gray_i;
      default:     res_o = c_i;
    endcase
  end

endmodule

// File: rtl/pixel_stream_proc.sv
// Two-stage streaming per-pixel processor with frame markers and frame counter.
module pixel_stream_proc
  import pixel_proc_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned WIDTH  = 768,
  parameter int unsigned HEIGHT = 512,
  parameter int unsigned CNT_W  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [2:0]            mode,
  input  logic                  bright_dir,
  input  logic [DATA_W-1:0]     bright_val,
  input  logic [DATA_W-1:0]     thresh,
  pixel_stream_proc_if.slave    bus,
  output logic [CNT_W-1:0]      frame_cnt,
  output logic                  busy
);

  localparam int unsigned PIX_W  = NUM_CH * DATA_W;
  localparam int unsigned GRAY_W = DATA_W + 2;
  localparam int unsigned COL_W  = (WIDTH  > 1) ? $clog2(WIDTH)  : 1;
  localparam int unsigned ROW_W  = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;

  logic              active_q;
  logic              s1_valid_q, s1_sof_q, s1_eol_q, s1_eof_q;
  logic [PIX_W-1:0]  s1_px_q;
  logic [DATA_W-1:0] s1_gray_q;
  logic              out_valid_q, out_sof_q, out_eol_q, out_eof_q;
  logic [PIX_W-1:0]  out_data_q;
  logic [COL_W-1:0]  col_q, col_d;
  logic [ROW_W-1:0]  row_q, row_d;
  logic [CNT_W-1:0]  frame_cnt_q, frame_cnt_d;
  logic              busy_q, busy_d;
  mode_e             mode_q;
  logic              dir_q;
  logic [DATA_W-1:0] val_q, thr_q;

  logic              in_ready, in_fire, out_fire, s2_adv;
  logic              first_px, last_col, last_row;
  logic [GRAY_W-1:0] gray_sum;
  logic [PIX_W-1:0]  res;

  // in_ready is held low until the first clock after reset release.
  assign s2_adv   = !out_valid_q || bus.out_ready;
  assign in_ready = active_q && (!s1_valid_q || s2_adv);
  assign in_fire  = bus.in_valid && in_ready;
  assign out_fire = out_valid_q && bus.out_ready;
  assign first_px = (col_q == '0) && (row_q == '0);
  assign last_col = (col_q == COL_W'(WIDTH - 1));
  assign last_row = (row_q == ROW_W'(HEIGHT - 1));
  assign gray_sum = GRAY_W'(bus.in_data[CH_R*DATA_W +: DATA_W])
                  + (GRAY_W'(bus.in_data[CH_G*DATA_W +: DATA_W]) << 1)
                  + GRAY_W'(bus.in_data[CH_B*DATA_W +: DATA_W]);

  // Raster position, frame counter and busy flag next-state.
  always_comb begin
    col_d       = col_q;
    row_d       = row_q;
    frame_cnt_d = frame_cnt_q;
    busy_d      = busy_q;
    if (in_fire) begin
      if (last_col) begin
        col_d = '0;
        row_d = last_row ? '0 : row_q + ROW_W'(1);
      end else begin
        col_d = col_q + COL_W'(1);
      end
    end
    if (out_fire && out_eof_q) frame_cnt_d = frame_cnt_q + CNT_W'(1);
    // A new frame starting wins over the previous frame finishing.
    if (in_fire && first_px)       busy_d = 1'b1;
    else if (out_fire && out_eof_q) busy_d = 1'b0;
  end

  // Control state and the per-frame parameter latch taken on the first pixel.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      active_q    <= 1'b0;
      col_q       <= '0;
      row_q       <= '0;
      frame_cnt_q <= '0;
      busy_q      <= 1'b0;
      mode_q      <= MODE_PASS;
      dir_q       <= 1'b0;
      val_q       <= '0;
      thr_q       <= '0;
    end else begin
      active_q    <= 1'b1;
      col_q       <= col_d;
      row_q       <= row_d;
      frame_cnt_q <= frame_cnt_d;
      busy_q      <= busy_d;
      if (in_fire && first_px) begin
        mode_q <= mode_e'(mode);
        dir_q  <= bright_dir;
        val_q  <= bright_val;
        thr_q  <= thresh;
      end
    end
  end

  // Stage 1: capture pixel, luma estimate and frame markers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_px_q    <= '0;
      s1_gray_q  <= '0;
      s1_sof_q   <= 1'b0;
      s1_eol_q   <= 1'b0;
      s1_eof_q   <= 1'b0;
    end else if (in_ready) begin
      s1_valid_q <= in_fire;
      if (in_fire) begin
        s1_px_q   <= bus.in_data;
        s1_gray_q <= gray_sum[GRAY_W-1:2];
        s1_sof_q  <= first_px;
        s1_eol_q  <= last_col;
        s1_eof_q  <= last_col && last_row;
      end
    end
  end

  for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
    pixel_op_channel #(.DATA_W(DATA_W)) u_op (
      .mode_i       (mode_q),
      .c_i          (s1_px_q[ch*DATA_W +: DATA_W]),
      .gray_i       (s1_gray_q),
      .bright_dir_i (dir_q),
      .bright_val_i (val_q),
      .thresh_i     (thr_q),
      .res_o        (res[ch*DATA_W +: DATA_W])
    );
  end

  // Stage 2: output register, held while the sink stalls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sof_q   <= 1'b0;
      out_eol_q   <= 1'b0;
      out_eof_q   <= 1'b0;
    end else if (s2_adv) begin
      out_valid_q <= s1_valid_q;
      out_data_q  <= res;
      out_sof_q   <= s1_sof_q;
      out_eol_q   <= s1_eol_q;
      out_eof_q   <= s1_eof_q;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_sof   = out_sof_q;
  assign bus.out_eol   = out_eol_q;
  assign bus.out_eof   = out_eof_q;
  assign frame_cnt     = frame_cnt_q;
  assign busy          = busy_q;

endmodule

// File: tb/tb_pixel_stream_proc.sv
// Scoreboard bench for pixel_stream_proc (DATA_W=8, WIDTH=4, HEIGHT=2).
module tb_pixel_stream_proc;

  localparam int W = 4;
  localparam int H = 2;
  localparam int NPIX = W * H;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] mode = 3'd0;
  logic       bright_dir = 1'b0;
  logic [7:0] bright_val = 8'd0;
  logic [7:0] thresh = 8'd0;
  logic [15:0] frame_cnt;
  logic       busy;

  pixel_stream_proc_if #(.DATA_W(8)) bus ();

  pixel_stream_proc #(.DATA_W(8), .WIDTH(W), .HEIGHT(H), .CNT_W(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .mode       (mode),
    .bright_dir (bright_dir),
    .bright_val (bright_val),
    .thresh     (thresh),
    .bus        (bus.slave),
    .frame_cnt  (frame_cnt),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [23:0] d;
    bit sof, eol, eof;
    int acc;
    bit lat;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int idx = 0;
  int exp_frames = 0;
  int acc_cnt = 0;
  bit lat_mode = 1'b0;
  int rdy_mode = 0;   // 0 ready high, 1 ready low, 2 random
  int lm, lval, lthr;
  bit ldir;

  always @(posedge clk) cyc++;

  always @(negedge clk)
    bus.out_ready = (rdy_mode == 2) ? (($urandom % 4) != 0) : (rdy_mode == 0);

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %0h want %0h (t=%0t)", name, got, want, $time);
    end
  endtask

  // Reference: clamp-based arithmetic on integer channel values.
  function automatic logic [23:0] model(input logic [23:0] px);
    int c[3];
    int o[3];
    int g;
    c[0] = int'(px[7:0]);
    c[1] = int'(px[15:8]);
    c[2] = int'(px[23:16]);
    g = (c[0] + 2 * c[1] + c[2]) / 4;
    for (int i = 0; i < 3; i++) begin
      case (lm)
        1: o[i] = ldir ? ((c[i] - lval < 0) ? 0 : c[i] - lval)
                       : ((c[i] + lval > 255) ? 255 : c[i] + lval);
        2: o[i] = 255 - c[i];
        3: o[i] = (g >= lthr) ? 255 : 0;
        4: o[i] = g;
        default: o[i] = c[i];
      endcase
    end
    return {8'(o[2]), 8'(o[1]), 8'(o[0])};
  endfunction

  task automatic send_px(input logic [23:0] px);
    int n = 0;
    exp_t e;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_data  = px;
    #1;
    while (!bus.in_ready && n < 200) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (!bus.in_ready) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout got in_ready=0 want 1 after %0d cycles", n);
    end else begin
      if (idx == 0) begin
        lm = int'(mode); ldir = bright_dir; lval = int'(bright_val); lthr = int'(thresh);
      end
      e.d   = model(px);
      e.sof = (idx == 0);
      e.eol = ((idx % W) == W - 1);
      e.eof = (idx == NPIX - 1);
      e.acc = cyc;
      e.lat = lat_mode;
      q.push_back(e);
      idx = (idx + 1) % NPIX;
      acc_cnt++;
    end
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
  endtask

  task automatic send_frame_const(input logic [23:0] px);
    for (int i = 0; i < NPIX; i++) send_px(px);
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("drain_queue_empty", 64'(q.size()), 64'd0);
  endtask

  // Monitor: compare each output transfer and check holding under stall.
  bit hold_pend = 1'b0;
  logic [26:0] hold_val;
  always @(negedge clk) begin
    exp_t e;
    #2;
    if (!rst) begin
      if (hold_pend) begin
        chk("hold_valid", 64'(bus.out_valid), 64'd1);
        chk("hold_payload", 64'({bus.out_data, bus.out_sof, bus.out_eol, bus.out_eof}), 64'(hold_val));
      end
      if (bus.out_valid && bus.out_ready) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_output got data %0h want none", bus.out_data);
        end else begin
          e = q.pop_front();
          chk("out_data", 64'(bus.out_data), 64'(e.d));
          chk("markers", 64'({bus.out_sof, bus.out_eol, bus.out_eof}), 64'({e.sof, e.eol, e.eof}));
          if (e.lat) chk("latency", 64'(cyc - e.acc), 64'd2);
          chk("frame_cnt", 64'(frame_cnt), 64'(exp_frames));
          if (e.eof) exp_frames++;
        end
      end
      hold_pend = bus.out_valid && !bus.out_ready;
      hold_val  = {bus.out_data, bus.out_sof, bus.out_eol, bus.out_eof};
    end else begin
      hold_pend = 1'b0;
    end
  end

  task automatic chk_all_zero(input string tag);
    chk({tag, "_in_ready"}, 64'(bus.in_ready), 64'd0);
    chk({tag, "_out_valid"}, 64'(bus.out_valid), 64'd0);
    chk({tag, "_out_data"}, 64'(bus.out_data), 64'd0);
    chk({tag, "_markers"}, 64'({bus.out_sof, bus.out_eol, bus.out_eof}), 64'd0);
    chk({tag, "_frame_cnt"}, 64'(frame_cnt), 64'd0);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
  endtask

  initial begin
    int a0;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    bus.out_ready = 1'b1;

    // Reset state and release
    #12 chk_all_zero("reset");
    #10 rst = 1'b0;
    @(negedge clk); #1;
    chk("ready_after_reset", 64'(bus.in_ready), 64'd1);

    // Gray frame, latency checked
    lat_mode = 1'b1;
    mode = 3'd4;
    for (int i = 0; i < 4; i++) send_px({8'd90, 8'd60, 8'd30});
    #1 chk("busy_mid_frame", 64'(busy), 64'd1);
    for (int i = 0; i < 4; i++) send_px({8'd90, 8'd60, 8'd30});
    drain();

    // Brightness up then down
    mode = 3'd1; bright_dir = 1'b0; bright_val = 8'd100;
    send_frame_const({8'd155, 8'd10, 8'd200});
    bright_dir = 1'b1;
    send_frame_const({8'd155, 8'd10, 8'd200});

    // Threshold boundary and inversion extremes
    mode = 3'd3; thresh = 8'd128;
    for (int i = 0; i < NPIX / 2; i++) begin
      send_px({8'd127, 8'd127, 8'd127});
      send_px({8'd128, 8'd128, 8'd128});
    end
    mode = 3'd2;
    send_frame_const({8'd255, 8'd1, 8'd0});

    // Mode change mid-frame only takes effect at next frame
    mode = 3'd4;
    for (int i = 0; i < 3; i++) send_px(24'($urandom));
    mode = 3'd2;
    for (int i = 3; i < NPIX; i++) send_px(24'($urandom));
    send_frame_const({8'd12, 8'd34, 8'd56});
    drain();

    // Backpressure for 5 clocks mid-line
    lat_mode = 1'b0;
    mode = 3'd0;
    fork
      for (int i = 0; i < NPIX; i++) send_px(24'($urandom));
      begin
        repeat (3) @(negedge clk);
        @(posedge clk);
        rdy_mode = 1;
        @(negedge clk); #2 a0 = acc_cnt;
        repeat (4) @(negedge clk);
        #2;
        chk("stall_in_ready", 64'(bus.in_ready), 64'd0);
        chk("stall_accepts_le2", 64'(acc_cnt - a0 <= 2), 64'd1);
        rdy_mode = 0;
      end
    join
    drain();

    // Asynchronous reset mid-frame
    lat_mode = 1'b1;
    mode = 3'd4;
    for (int i = 0; i < 5; i++) send_px(24'($urandom));
    @(negedge clk);
    #3 rst = 1'b1;
    #1 chk_all_zero("async_reset");
    q.delete();
    idx = 0;
    exp_frames = 0;
    @(posedge clk);
    #3 rst = 1'b0;
    @(negedge clk);
    @(negedge clk); #1;
    chk("ready_after_rst2", 64'(bus.in_ready), 64'd1);
    mode = 3'd0;
    send_frame_const({8'd1, 8'd2, 8'd3});
    drain();

    // Randomized frames with random sink stalls and input gaps
    lat_mode = 1'b0;
    rdy_mode = 2;
    for (int f = 0; f < 6; f++) begin
      for (int i = 0; i < NPIX; i++) begin
        mode       = 3'($urandom_range(0, 7));
        bright_dir = 1'($urandom);
        bright_val = 8'($urandom);
        thresh     = 8'($urandom);
        repeat ($urandom % 3) @(negedge clk);
        send_px(24'($urandom));
      end
    end
    rdy_mode = 0;
    drain();
    repeat (2) @(negedge clk);
    #3;
    chk("final_frame_cnt", 64'(frame_cnt), 64'(exp_frames));
    chk("final_busy", 64'(busy), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/pixel_stream_proc.md
Name: pixel_stream_proc

Overview:
Streaming per-pixel image processor; successor to the file-based grayscale/brightness/inversion/threshold flow.
- Accepts packed RGB pixels over a valid/ready stream in raster order.
- Applies one frame-wide point operation and emits the result with frame markers.
- Sits between the pixel source (hex/BMP loader or camera front end) and the output writer.
- Parametrised in channel width, frame dimensions and brightness/threshold behaviour.

Parameters:
DATA_W, 8, bits per colour channel
WIDTH, 768, pixels per line
HEIGHT, 512, lines per frame
CNT_W, 16, width of frame counter output

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
mode  in  3  operation select, sampled at frame start
bright_dir  in  1  0 = increase brightness, 1 = decrease
bright_val  in  DATA_W  brightness offset
thresh  in  DATA_W  threshold level
in_valid  in  1  input pixel valid
in_ready  out  1  block can accept a pixel
in_data  in  3*DATA_W  {B,G,R}; R in [DATA_W-1:0]
out_valid  out  1  output pixel valid
out_ready  in  1  sink accepts pixel
out_data  out  3*DATA_W  processed {B,G,R}
out_sof  out  1  first pixel of frame, qualified by out_valid
out_eol  out  1  last pixel of line
out_eof  out  1  last pixel of frame
frame_cnt  out  CNT_W  completed frames, wraps at 2^CNT_W
busy  out  1  frame in progress (first pixel accepted, last not yet output)

Behaviour:
- Reset: one clock `clk`; reset `rst` is asynchronous and active-high. While rst is high, every output is 0, including in_ready. Counters, pipeline valids and the latched mode are also cleared. in_ready is 1 on the first clock after rst deasserts.
- Reset mid-frame: the partial frame is discarded. The next accepted pixel is treated as the frame's first pixel (col = 0, row = 0).
- Handshake:
  - Transfer occurs when valid && ready.
  - out_data, out_valid and all markers hold stable while out_valid && !out_ready.
  - in_ready = !s1_valid || s2_adv, where s2_adv = !s2_valid || out_ready. This is a 2-stage pipeline with full throughput (1 pixel/clk) under no backpressure.
- Latency: 2 clocks from input transfer to out_valid.
- Stage 1 (register on input accept):
  - capture R, G, B;
  - compute gray = (R + 2G + B) >> 2 at DATA_W+2 bits, truncated to DATA_W;
  - attach sof/eol/eof from the input col/row counters.
- Stage 2: apply the latched mode. MAX = 2^DATA_W - 1.
  - 0 PASS: unchanged.
  - 1 BRIGHT: each channel is c + bright_val, saturating at MAX (dir 0), or c - bright_val, saturating at 0 (dir 1).
  - 2 INVERT: each channel = MAX - c.
  - 3 THRESH: all channels = MAX if gray >= thresh, else 0.
  - 4 GRAY: all channels = gray.
  - 5..7: treated as PASS.
- Mode, bright_dir, bright_val and thresh are latched on the input transfer with col == 0 and row == 0. They are held for the whole frame, so changes mid-frame have no effect until the next frame.
- Counters:
  - col increments on each input transfer and wraps at WIDTH-1 to 0, which increments row.
  - row wraps at HEIGHT-1 to 0, which ends the frame.
- Markers: sof at (0,0); eol at col == WIDTH-1; eof at (WIDTH-1, HEIGHT-1). For WIDTH = 1, eol is set on every pixel.
- frame_cnt increments on the output transfer carrying eof.
- busy: set on the sof input transfer, cleared on the eof output transfer. If both occur in the same cycle (back-to-back frames), busy stays 1.

Decomposition:
- Package pixel_proc_pkg:
  - mode encodings MODE_PASS/BRIGHT/INVERT/THRESH/GRAY;
  - channel index constants CH_R = 0, CH_G = 1, CH_B = 2;
  - helper function for saturating add/sub.
- Sub-module pixel_op_channel (DATA_W): one channel's stage-2 datapath (mode, c, gray, params -> result). Instantiated 3 times.

Test Plan:
(All tests use DATA_W=8, WIDTH=4, HEIGHT=2.)
1. Mode 4, pixel R=30 G=60 B=90, out_ready=1 -> out_data all channels 60, exactly 2 clocks after accept. 8 pixels give sof on #0, eol on #3 and #7, eof on #7, frame_cnt=1.
2. Mode 1, dir 0, val 100, R=200 G=10 B=155 -> 255, 110, 255. Dir 1, val 100, same pixel -> 100, 0, 55.
3. Mode 3, thresh 128: gray 127 -> 0,0,0; gray 128 -> 255,255,255. Mode 2 on R=0 G=1 B=255 -> 255, 254, 0.
4. Backpressure: out_ready low for 5 clocks mid-line -> in_ready drops after 2 more accepts, out_data is held stable, no pixel is lost or duplicated, and the marker sequence is intact.
5. Mode changed from 4 to 2 at pixel 3 -> frame 0 stays all gray; inversion starts at frame 1 sof.
6. rst pulsed asynchronously (not clock-aligned) at pixel 5 -> all outputs 0 immediately. Next accepted pixel produces out_sof=1; frame_cnt stays 0 until a full 8 pixels are output.
